// File: rtl/ps2_pkg.sv
// PS/2 receive types: frame/packet FSM states, byte0 field layout and axis clamp helper.
package ps2_pkg;

    typedef enum logic [1:0] {FrmIdle, FrmData, FrmParity, FrmStop} frame_state_e;
    typedef enum logic [1:0] {PktB0, PktB1, PktB2, PktUpd} pkt_state_e;

    localparam int unsigned B0_LEFT  = 0;
    localparam int unsigned B0_RIGHT = 1;
    localparam int unsigned B0_SYNC  = 3;
    localparam int unsigned B0_XSIGN = 4;
    localparam int unsigned B0_YSIGN = 5;
    localparam int unsigned B0_XOVF  = 6;
    localparam int unsigned B0_YOVF  = 7;

    typedef struct packed {
        logic yovf;
        logic xovf;
        logic ysign;
        logic xsign;
        logic right;
        logic left;
    } hdr_t;

    function automatic logic [11:0] clamp_axis(input logic signed [13:0] v,
                                               input logic [11:0] max);
        if (v < 14'sd0) begin
            return 12'd0;
        end else if (v > $signed({2'b00, max})) begin
            return max;
        end else begin
            return v[11:0];
        end
    endfunction

endpackage

// File: rtl/vga_pkg.sv
// Timing constants for the 800x600 visible area shared by the pixel-domain blocks.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 800;
    localparam int unsigned V_VISIBLE = 600;
    localparam int unsigned VGA_H_MAX = H_VISIBLE - 1;
    localparam int unsigned VGA_V_MAX = V_VISIBLE - 1;

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host byte receiver: synchroniser, clock glitch filter, 11-bit frame FSM
// and inactivity timeout that also covers a partially received packet upstream.
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 40000
) (
    input  logic       clk40MHz,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       pkt_busy,
    output logic       byte_valid,
    output logic [7:0] rx_data,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [1:0]   clk_sync_q, data_sync_q;
    logic         filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         parity_ok_q, parity_ok_d;
    logic         strobe, sdata, timeout;

    always_comb begin
        filt_clk_d  = filt_clk_q;
        filt_cnt_d  = '0;
        to_cnt_d    = to_cnt_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_ok_d = parity_ok_q;
        byte_valid  = 1'b0;
        frame_err   = 1'b0;
        sdata       = data_sync_q[1];

        if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
        strobe = filt_clk_q & ~filt_clk_d;

        // Counter parks at TIMEOUT so an expiry fires exactly once per idle stretch
        if (strobe) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TW'(TIMEOUT)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
        timeout = !strobe && (to_cnt_q == TW'(TIMEOUT - 1)) &&
                  ((state_q != FrmIdle) || pkt_busy);

        if (timeout) begin
            state_d   = FrmIdle;
            frame_err = 1'b1;
        end else if (strobe) begin
            unique case (state_q)
                FrmIdle: begin
                    if (!sdata) begin
                        state_d   = FrmData;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                FrmData: begin
                    shift_d   = {sdata, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = FrmParity;
                end
                FrmParity: begin
                    parity_ok_d = ^{shift_q, sdata};
                    state_d     = FrmStop;
                end
                FrmStop: begin
                    state_d = FrmIdle;
                    if (sdata && parity_ok_q) byte_valid = 1'b1;
                    else                      frame_err  = 1'b1;
                end
                default: state_d = FrmIdle;
            endcase
        end
    end

    assign rx_data = shift_q;

    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            to_cnt_q    <= '0;
            state_q     <= FrmIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_ok_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            to_cnt_q    <= to_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_ok_q <= parity_ok_d;
        end
    end

endmodule

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse front end: assembles 3-byte movement packets and keeps a clamped absolute
// cursor position and button state for the pixel-domain overlay.
module ps2_mouse_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned H_MAX      = vga_pkg::VGA_H_MAX,
    parameter int unsigned V_MAX      = vga_pkg::VGA_V_MAX,
    parameter int unsigned X_INIT     = 400,
    parameter int unsigned Y_INIT     = 300,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 40000
) (
    input  logic        clk40MHz,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left,
    output logic        right,
    output logic        mouse_event,
    output logic        frame_err
);

    logic       rx_valid, rx_err, pkt_busy;
    logic [7:0] rx_data;

    pkt_state_e pkt_q, pkt_d;
    hdr_t       hdr_q, hdr_d;
    logic [7:0] dx_q, dx_d;
    logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic       left_q, left_d, right_q, right_d;
    logic       event_q, event_d, frame_err_q, frame_err_d;
    logic signed [13:0] dx_ext, dy_ext, nx, ny;

    ps2_rx_byte #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk40MHz   (clk40MHz),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .pkt_busy   (pkt_busy),
        .byte_valid (rx_valid),
        .rx_data    (rx_data),
        .frame_err  (rx_err)
    );

    assign pkt_busy = (pkt_q != PktB0);

    always_comb begin
        pkt_d       = pkt_q;
        hdr_d       = hdr_q;
        dx_d        = dx_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        left_d      = left_q;
        right_d     = right_q;
        event_d     = 1'b0;
        frame_err_d = rx_err;

        // Overflowed axes contribute nothing; otherwise {sign, byte} sign-extended
        dx_ext = hdr_q.xovf ? 14'sd0 : $signed({{6{hdr_q.xsign}}, dx_q});
        dy_ext = hdr_q.yovf ? 14'sd0 : $signed({{6{hdr_q.ysign}}, rx_data});
        nx     = $signed({2'b00, xpos_q}) + dx_ext;
        ny     = $signed({2'b00, ypos_q}) - dy_ext;

        if (rx_err) begin
            pkt_d = PktB0;
        end else begin
            unique case (pkt_q)
                PktB0: begin
                    if (rx_valid && rx_data[B0_SYNC]) begin
                        hdr_d = '{yovf:  rx_data[B0_YOVF],  xovf:  rx_data[B0_XOVF],
                                  ysign: rx_data[B0_YSIGN], xsign: rx_data[B0_XSIGN],
                                  right: rx_data[B0_RIGHT], left:  rx_data[B0_LEFT]};
                        pkt_d = PktB1;
                    end
                end
                PktB1: begin
                    if (rx_valid) begin
                        dx_d  = rx_data;
                        pkt_d = PktB2;
                    end
                end
                PktB2: begin
                    if (rx_valid) begin
                        xpos_d  = clamp_axis(nx, 12'(H_MAX));
                        ypos_d  = clamp_axis(ny, 12'(V_MAX));
                        left_d  = hdr_q.left;
                        right_d = hdr_q.right;
                        event_d = 1'b1;
                        pkt_d   = PktUpd;
                    end
                end
                PktUpd:  pkt_d = PktB0;
                default: pkt_d = PktB0;
            endcase
        end
    end

    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            pkt_q       <= PktB0;
            hdr_q       <= '0;
            dx_q        <= '0;
            xpos_q      <= 12'(X_INIT);
            ypos_q      <= 12'(Y_INIT);
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            event_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            pkt_q       <= pkt_d;
            hdr_q       <= hdr_d;
            dx_q        <= dx_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            left_q      <= left_d;
            right_q     <= right_d;
            event_q     <= event_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign left        = left_q;
    assign right       = right_q;
    assign mouse_event = event_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Directed bench for ps2_mouse_decoder: packet vector table plus error/timeout/reset sequences.
module tb_ps2_mouse_decoder;

    localparam int HALF = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [11:0] xpos, ypos;
    logic        left, right, mouse_event, frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int ev_cnt = 0;
    int fe_cnt = 0;
    int ev_base, fe_base;

    typedef struct packed {
        logic        rst_first;
        logic [7:0]  b0, b1, b2;
        logic [11:0] ex, ey;
        logic        el, er;
    } vec_t;

    vec_t vecs [24];

    always #12.5 clk = ~clk;

    ps2_mouse_decoder dut (
        .clk40MHz    (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .xpos        (xpos),
        .ypos        (ypos),
        .left        (left),
        .right       (right),
        .mouse_event (mouse_event),
        .frame_err   (frame_err)
    );

    always @(negedge clk) begin
        if (mouse_event) ev_cnt <= ev_cnt + 1;
        if (frame_err)   fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic snap();
        @(negedge clk);
        ev_base = ev_cnt;
        fe_base = fe_cnt;
    endtask

    // Frame bits: start, 8 data LSB first, odd parity, stop; nbits < 11 truncates the frame
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 1'b0, 11);
        send_frame(b1, 1'b0, 11);
        send_frame(b2, 1'b0, 11);
        repeat (30) @(negedge clk);
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, " xpos"}, int'(xpos), ex);
        check({tag, " ypos"}, int'(ypos), ey);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h08, 8'h0A, 8'h05, 12'd410, 12'd295, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h39, 8'hF6, 8'hFB, 12'd390, 12'd305, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h08, 8'h7F, 8'h00, 12'd527, 12'd300, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h08, 8'h7F, 8'h00, 12'd654, 12'd300, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h08, 8'h7F, 8'h00, 12'd781, 12'd300, 1'b0, 1'b0};
        for (int i = 5; i < 12; i++) begin
            vecs[i] = '{1'b0, 8'h08, 8'h7F, 8'h00, 12'd799, 12'd300, 1'b0, 1'b0};
        end
        vecs[12] = '{1'b0, 8'h28, 8'h00, 8'h00, 12'd799, 12'd556, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h28, 8'h00, 8'h00, 12'd799, 12'd599, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'h4A, 8'h50, 8'h00, 12'd799, 12'd599, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 8'h18, 8'h00, 8'h00, 12'd543, 12'd599, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 8'h18, 8'h00, 8'h00, 12'd287, 12'd599, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 8'h18, 8'h00, 8'h00, 12'd31,  12'd599, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 8'h18, 8'h00, 8'h00, 12'd0,   12'd599, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 8'h08, 8'h00, 8'hFF, 12'd0,   12'd344, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 8'h08, 8'h00, 8'hFF, 12'd0,   12'd89,  1'b0, 1'b0};
        vecs[21] = '{1'b0, 8'h08, 8'h00, 8'hFF, 12'd0,   12'd0,   1'b0, 1'b0};
        vecs[22] = '{1'b0, 8'h88, 8'h00, 8'h80, 12'd0,   12'd0,   1'b0, 1'b0};
        vecs[23] = '{1'b0, 8'h0B, 8'h05, 8'h00, 12'd5,   12'd0,   1'b1, 1'b1};

        do_reset();
        check_pos("reset", 400, 300);
        check("reset left", int'(left), 0);
        check("reset right", int'(right), 0);
        check("reset event", int'(mouse_event), 0);
        check("reset frame_err", int'(frame_err), 0);

        for (int i = 0; i < 24; i++) begin
            if (vecs[i].rst_first) do_reset();
            snap();
            send_packet(vecs[i].b0, vecs[i].b1, vecs[i].b2);
            check_pos($sformatf("vec%0d", i), int'(vecs[i].ex), int'(vecs[i].ey));
            check($sformatf("vec%0d left", i), int'(left), int'(vecs[i].el));
            check($sformatf("vec%0d right", i), int'(right), int'(vecs[i].er));
            check($sformatf("vec%0d events", i), ev_cnt - ev_base, 1);
            check($sformatf("vec%0d frame_errs", i), fe_cnt - fe_base, 0);
        end

        // Bad parity on byte1 aborts the packet; the next one decodes cleanly
        do_reset();
        snap();
        send_frame(8'h08, 1'b0, 11);
        send_frame(8'h0A, 1'b1, 11);
        repeat (30) @(negedge clk);
        check("parity frame_errs", fe_cnt - fe_base, 1);
        check("parity events", ev_cnt - ev_base, 0);
        check_pos("parity hold", 400, 300);
        snap();
        send_packet(8'h08, 8'h0A, 8'h05);
        check_pos("after parity", 410, 295);
        check("after parity events", ev_cnt - ev_base, 1);
        check("after parity frame_errs", fe_cnt - fe_base, 0);

        // Stray byte without the sync bit is dropped silently
        do_reset();
        snap();
        send_frame(8'h00, 1'b0, 11);
        send_packet(8'h08, 8'h0A, 8'h05);
        check_pos("stray", 410, 295);
        check("stray events", ev_cnt - ev_base, 1);
        check("stray frame_errs", fe_cnt - fe_base, 0);

        // Clock stops after byte0 long enough to trip the timeout
        do_reset();
        snap();
        send_frame(8'h08, 1'b0, 11);
        repeat (41000) @(negedge clk);
        check("timeout frame_errs", fe_cnt - fe_base, 1);
        check("timeout events", ev_cnt - ev_base, 0);
        snap();
        send_packet(8'h08, 8'h0A, 8'h05);
        check_pos("after timeout", 410, 295);
        check("after timeout events", ev_cnt - ev_base, 1);

        // Reset in the middle of a frame discards it and restores the initial position
        do_reset();
        send_packet(8'h08, 8'h0A, 8'h05);
        check_pos("pre midreset", 410, 295);
        snap();
        send_frame(8'h08, 1'b0, 4);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check_pos("midreset", 400, 300);
        check("midreset events", ev_cnt - ev_base, 0);
        check("midreset frame_errs", fe_cnt - fe_base, 0);
        snap();
        send_packet(8'h39, 8'hF6, 8'hFB);
        check_pos("after midreset", 390, 305);
        check("after midreset left", int'(left), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
